// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_arbiter_pkg: state encodings, master ids and sram-like size codes for the cache bus arbiter
package cache_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;
  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
endpackage

// File: rtl/cache_bus_arbiter_if.sv
// cache_bus_arbiter_if: icache, dcache and AXI-bridge sram-like signals; slave = arbiter side, master = environment side
interface cache_bus_arbiter_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic i_req, i_wr, i_addr_ok, i_data_ok;
  logic [1:0] i_size;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata, i_rdata;
  logic d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0] d_size;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata, d_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0] mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  modport slave (
    input i_req, i_wr, i_size, i_addr, i_wdata, d_req, d_wr, d_size, d_addr, d_wdata,
    input mem_rdata, mem_addr_ok, mem_data_ok,
    output i_rdata, i_addr_ok, i_data_ok, d_rdata, d_addr_ok, d_data_ok,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_wr, i_size, i_addr, i_wdata, d_req, d_wr, d_size, d_addr, d_wdata,
    output mem_rdata, mem_addr_ok, mem_data_ok,
    input i_rdata, i_addr_ok, i_data_ok, d_rdata, d_addr_ok, d_data_ok,
    input mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one sram-like memory port between icache and dcache, one transaction at a time; define ARB_RR_EN for round-robin instead of D-over-I priority
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  cache_bus_arbiter_if.slave bus
);
  state_t state;
  logic owner, sel, cur, any_req, owner_req, fwd, hs, dok;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
`ifdef ARB_RR_EN
  logic last_grant;
  assign sel = bus.d_req && bus.i_req ? (last_grant == MST_D ? MST_I : MST_D) : (bus.d_req ? MST_D : MST_I);
`else
  assign sel = bus.d_req ? MST_D : MST_I;
`endif
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
  // forward the idle winner or the locked owner, and route handshakes only to that master
  always_comb begin
    any_req = bus.i_req || bus.d_req;
    owner_req = owner == MST_D ? bus.d_req : bus.i_req;
    cur = state == IDLE ? sel : owner;
    fwd = state == IDLE ? any_req : (state == ADDR && owner_req);
    hs = fwd && bus.mem_addr_ok;
    dok = state == DATA && bus.mem_data_ok;
    cur_addr = cur == MST_D ? bus.d_addr : bus.i_addr;
    cur_wdata = cur == MST_D ? bus.d_wdata : bus.i_wdata;
    bus.mem_req = fwd;
    bus.mem_wr = fwd && (cur == MST_D ? bus.d_wr : bus.i_wr);
    bus.mem_size = fwd ? (cur == MST_D ? bus.d_size : bus.i_size) : 2'b00;
    bus.mem_addr = fwd ? cur_addr : '0;
    bus.mem_wdata = fwd ? cur_wdata : '0;
    bus.i_addr_ok = hs && cur == MST_I;
    bus.d_addr_ok = hs && cur == MST_D;
    bus.i_data_ok = dok && owner == MST_I;
    bus.d_data_ok = dok && owner == MST_D;
  end
  // transaction sequencing IDLE -> (ADDR) -> DATA -> IDLE with the owner locked from grant to data_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= MST_D;
`ifdef ARB_RR_EN
      last_grant <= MST_I;
`endif
    end else begin
      if (state == IDLE && any_req) owner <= sel;
`ifdef ARB_RR_EN
      if (hs) last_grant <= cur;
`endif
      state <= state == IDLE ? (any_req ? (bus.mem_addr_ok ? DATA : ADDR) : IDLE)
             : state == ADDR ? (!owner_req ? IDLE : (bus.mem_addr_ok ? DATA : ADDR))
             : state == DATA ? (dok ? IDLE : DATA)
             : IDLE;
    end
  end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: randomized cache masters and AXI bridge against a transaction-level model with a data-response scoreboard
module tb_cache_bus_arbiter;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {int m; logic [31:0] rd;} exp_t;
  logic clk = 1'b0;
  logic rst;
  cache_bus_arbiter_if b ();
  cache_bus_arbiter dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  int total = 0, passed = 0;
  exp_t q[$];
  int own = -1, lastg = 0, dly = 0;
  bit acc = 0, pend = 0, inj = 0, late = 0, quiet = 0;
  bit rq[2], w[2];
  logic [1:0] sz[2];
  logic [31:0] a[2], wd[2];
  logic [31:0] prd;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
    else passed++;
  endfunction
  task automatic drive();
    rst = inj;
    b.i_req = rq[0]; b.i_wr = w[0]; b.i_size = sz[0]; b.i_addr = a[0]; b.i_wdata = wd[0];
    b.d_req = rq[1]; b.d_wr = w[1]; b.d_size = sz[1]; b.d_addr = a[1]; b.d_wdata = wd[1];
    b.mem_addr_ok = 1'($urandom_range(0, 1));
    b.mem_data_ok = late || (!inj && (pend ? dly == 0 : $urandom_range(0, 7) == 0));
    b.mem_rdata = (pend && dly == 0) ? prd : $urandom;
  endtask
  task automatic step();
    int f;
    bit hs, dok, was_rst;
    f = -1;
    if (own < 0) begin
      if (rq[0] && rq[1]) f = RR ? (lastg == 1 ? 0 : 1) : 1;
      else if (rq[1]) f = 1;
      else if (rq[0]) f = 0;
    end else if (!acc && rq[own]) f = own;
    hs = f >= 0 && b.mem_addr_ok;
    dok = own >= 0 && acc && b.mem_data_ok;
    chk("mem_req", b.mem_req, f >= 0);
    chk("mem_addr", b.mem_addr, f >= 0 ? a[f] : 32'h0);
    chk("mem_wr", b.mem_wr, f >= 0 ? w[f] : 1'b0);
    chk("mem_size", b.mem_size, f >= 0 ? sz[f] : 2'b00);
    if (f >= 0) chk("mem_wdata", b.mem_wdata, wd[f]);
    chk("i_addr_ok", b.i_addr_ok, hs && f == 0);
    chk("d_addr_ok", b.d_addr_ok, hs && f == 1);
    chk("i_data_ok", b.i_data_ok, dok && own == 0);
    chk("d_data_ok", b.d_data_ok, dok && own == 1);
    was_rst = inj;
    inj = 0;
    late = 0;
    if (was_rst) begin
      own = -1; acc = 0; lastg = 0; pend = 0;
      q.delete();
      late = 1;
    end else if (dok) begin
      own = -1; acc = 0; pend = 0;
    end else if (f >= 0) begin
      own = f;
      if (hs) begin
        acc = 1; lastg = f; pend = 1;
        prd = $urandom;
        dly = $urandom_range(0, 3);
        q.push_back('{m: f, rd: prd});
        rq[f] = 0;
      end
    end else if (own >= 0 && !acc) own = -1;
    else if (pend && dly > 0) dly--;
    if (!quiet && acc && $urandom_range(0, 39) == 0) begin
      inj = 1; rq[0] = 0; rq[1] = 0;
    end
    for (int m = 0; m < 2; m++) begin
      if (quiet || inj || late) continue;
      if (rq[m] && $urandom_range(0, 24) == 0) rq[m] = 0;
      else if (!rq[m] && $urandom_range(0, 2) == 0) begin
        rq[m] = 1;
        w[m] = 1'($urandom_range(0, 1));
        sz[m] = 2'($urandom_range(0, 2));
        a[m] = $urandom;
        wd[m] = $urandom;
      end
    end
  endtask
  // scoreboard: every data_ok the arbiter shows must match the oldest accepted transaction
  always @(negedge clk) begin
    if (rst === 1'b0 && (b.i_data_ok === 1'b1 || b.d_data_ok === 1'b1)) begin
      if (q.size() == 0) chk("unexpected_data_ok", {b.i_data_ok, b.d_data_ok}, 2'b00);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("data_ok_owner", {b.i_data_ok, b.d_data_ok}, e.m == 1 ? 2'b01 : 2'b10);
        chk("i_rdata", b.i_rdata, e.rd);
        chk("d_rdata", b.d_rdata, e.rd);
      end
    end
  end
  initial begin
    for (int m = 0; m < 2; m++) begin
      rq[m] = 0; w[m] = 0; sz[m] = 0; a[m] = 0; wd[m] = 0;
    end
    inj = 1;
    drive();
    b.mem_data_ok = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mem_req", b.mem_req, 1'b0);
    chk("rst_addr_ok", {b.i_addr_ok, b.d_addr_ok}, 2'b00);
    chk("rst_data_ok", {b.i_data_ok, b.d_data_ok}, 2'b00);
    inj = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      quiet = i >= 3900;
      drive();
      @(negedge clk);
      step();
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single sram-like memory port toward the AXI interface between the instruction cache and the data cache.
- Arbitrates only when idle, then locks the winner from request until data_ok.
- Allows one outstanding transaction at a time.
- Sits between i_cache/d_cache (cache_* sram-like masters) and the AXI bridge.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_req  input  1  icache request
i_wr  input  1  icache write flag
i_size  input  2  icache access size
i_addr  input  ADDR_WIDTH  icache address
i_wdata  input  DATA_WIDTH  icache write data
i_rdata  output  DATA_WIDTH  read data to icache
i_addr_ok  output  1  address handshake to icache
i_data_ok  output  1  data handshake to icache
d_req, d_wr, d_size, d_addr, d_wdata  input  1/1/2/ADDR_WIDTH/DATA_WIDTH  dcache request fields (same meaning as i_*)
d_rdata, d_addr_ok, d_data_ok  output  DATA_WIDTH/1/1  dcache returns
mem_req, mem_wr  output  1/1  request and write flag to AXI bridge
mem_size  output  2  access size to AXI bridge
mem_addr  output  ADDR_WIDTH  address to AXI bridge
mem_wdata  output  DATA_WIDTH  write data to AXI bridge
mem_rdata  input  DATA_WIDTH  read data from AXI bridge
mem_addr_ok, mem_data_ok  input  1/1  handshakes from AXI bridge

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset state: IDLE, owner register = D, last_grant = I.
- Outputs at reset: mem_req=0, all *_addr_ok=0, all *_data_ok=0.
- States: IDLE, ADDR (request presented, awaiting mem_addr_ok), DATA (awaiting mem_data_ok).
- IDLE:
  - sel = D if d_req, else I if i_req, else none.
  - Selected master's req/wr/size/addr/wdata are forwarded combinationally to mem_* in the same cycle (zero-cycle grant).
  - If mem_addr_ok is high: assert sel_addr_ok, latch owner=sel, next state DATA.
  - If mem_addr_ok is low with a request: latch owner=sel, next state ADDR.
  - With no request: mem_req=0.
- ADDR:
  - Forward the owner's fields only; no preemption, even if the other master requests.
  - On mem_addr_ok: assert owner_addr_ok, next state DATA.
  - If the owner's req drops (protocol violation): mem_req=0, next state IDLE.
- DATA:
  - mem_req=0.
  - On mem_data_ok: assert owner_data_ok for one cycle, next state IDLE.
  - No new request is forwarded in that cycle; back-to-back transactions therefore have a one-cycle bubble.
- mem_rdata is broadcast to both i_rdata and d_rdata. addr_ok and data_ok go to the owner only; the non-owner always sees 0.
- mem_data_ok outside DATA is ignored; no *_data_ok is asserted.
- mem_size, mem_wr and mem_addr are driven 0 when no master is forwarded.
- Reset mid-transaction: return to IDLE and drop the outstanding transaction. The AXI bridge shares rst.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: when both masters request in IDLE, grant the one that is not last_grant. last_grant updates on each address handshake.
- Undefined: fixed priority, D over I; last_grant is unused and optimized away.

Decomposition:
- Shared package: state encodings (IDLE=2'b00, ADDR=2'b01, DATA=2'b10), master id constants (MST_I=0, MST_D=1), and the sram-like size constants (byte/half/word).
- No sub-module; the request mux is inline.

Test Plan:
- Single dcache read at addr 0x1000_0004 with mem_addr_ok in the same cycle and data_ok 3 cycles later with 0xDEADBEEF:
  - d_addr_ok in cycle 0.
  - d_data_ok in cycle 3 with d_rdata=0xDEADBEEF.
  - i_* handshakes stay 0.
- Simultaneous i_req and d_req, both held:
  - Without ARB_RR_EN: D is served first, I starts the cycle after d_data_ok+1.
  - With ARB_RR_EN and last_grant=D: I is served first.
- Owner lock: icache granted, mem_addr_ok delayed 4 cycles, d_req rises in cycle 1 → mem_addr stays the icache address until the handshake, and d_addr_ok=0 throughout.
- Dcache write 0x8000_0010 with wdata 0x12345678 and size 2'b10 → mem_wr=1 and fields match exactly; mem_data_ok outside DATA causes no data_ok pulse.
- Reset asserted while in DATA → next cycle state=IDLE and mem_req=0; a late mem_data_ok produces no *_data_ok.
